// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the core data bus.
// Contents: register offsets, STATUS bit positions, UART transmitter states.
package riscv_mmio_pkg;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

   // STATUS register layout (all other bits read as zero)
   localparam int unsigned ST_BUSY  = 0;
   localparam int unsigned ST_FULL  = 1;
   localparam int unsigned ST_EMPTY = 2;
   localparam int unsigned ST_OVF   = 3;
   localparam int unsigned ST_W     = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     write request and data
//   pop             read request; rdata is the current head
//   full, empty     occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the core data bus.
// Stores to TXDATA queue a byte in a FIFO; the FSM serializes bytes LSB first
// with one start and one stop bit (8N1), or 8E1 when UART_TX_PARITY_EN is
// defined (even parity bit between the data and the stop bit).
// Ports:
//   clk, reset     core clock, asynchronous active-high reset
//   bus_addr       byte address; exact match on BASE_ADDR (TXDATA) or +4 (STATUS)
//   bus_wdata      store data: [7:0] for TXDATA, [3] clears overflow in STATUS
//   bus_we/bus_re  single-cycle store/load strobes
//   bus_rdata      registered load data, held until the next load
//   uart_tx        serial output, idles high
//   tx_busy        frame on the line or bytes still queued
// STATUS = {28'b0, overflow, fifo_empty, fifo_full, tx_busy}
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high; pops the FIFO head into the shift register
// S_START  | start bit (0) for CLK_DIV cycles
// S_DATA   | 8 data bits LSB first, CLK_DIV cycles each
// S_PARITY | even parity bit for CLK_DIV cycles (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (1) for CLK_DIV cycles
module mmio_uart_tx
   import riscv_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic        bus_we,
   input  logic        bus_re,
   output logic [31:0] bus_rdata,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

   uart_state_t     state;
   uart_state_t     state_next;
   logic [15:0]     baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift_q;
   logic            bit_done;
   logic            line_next;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [7:0]      fifo_rdata;
   logic            sel_txdata;
   logic            sel_status;
   logic            txdata_wr;
   logic            ovf_set;
   logic            ovf_clr;
   logic            ovf_q;
   logic [ST_W-1:0] status;
   logic            unused_wdata;

`ifdef UART_TX_PARITY_EN
   logic parity_q;
`endif

   assign unused_wdata = ^bus_wdata[31:8];

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   assign sel_txdata = (bus_addr == BASE_ADDR + TXDATA_OFS);
   assign sel_status = (bus_addr == BASE_ADDR + STATUS_OFS);
   assign txdata_wr  = bus_we & sel_txdata;

   // A full FIFO still takes the byte if the FSM pops in the same cycle.
   assign ovf_set = txdata_wr & fifo_full & ~fifo_pop;
   assign ovf_clr = bus_we & sel_status & bus_wdata[ST_OVF];

   always_comb begin
      status           = '0;
      status[ST_BUSY]  = tx_busy;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_OVF]   = ovf_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q     <= 1'b0;
         bus_rdata <= '0;
      end else begin
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
         // Captures pre-write values, so a colliding store is not visible.
         if (bus_re) bus_rdata <= sel_status ? {{(32-ST_W){1'b0}}, status} : '0;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (txdata_wr),
      .pop   (fifo_pop),
      .wdata (bus_wdata[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   assign bit_done = (baud_cnt == '0);

   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      line_next  = 1'b1;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = S_START;
            end
         end
         S_START: begin
            line_next = 1'b0;
            if (bit_done) state_next = S_DATA;
         end
         S_DATA: begin
            line_next = shift_q[0];
            if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_next = S_PARITY;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            line_next = parity_q;
            if (bit_done) state_next = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_done) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // uart_tx is registered from the current state, so the whole frame lags
   // the state by one cycle; this keeps the line glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         uart_tx  <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         state   <= state_next;
         uart_tx <= line_next;
         tx_busy <= (state != S_IDLE) | ~fifo_empty;

         if (fifo_pop)                       shift_q <= fifo_rdata;
         else if (state == S_DATA && bit_done) shift_q <= shift_q >> 1;

         if (state_next != state || (state == S_DATA && bit_done))
            baud_cnt <= BAUD_RELOAD;
         else if (!bit_done)
            baud_cnt <= baud_cnt - 1'b1;

         // Wraps 7 -> 0 on the last data bit, ready for the next frame.
         if (state == S_DATA && bit_done) bit_cnt <= bit_cnt + 1'b1;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         parity_q <= 1'b0;
      else if (fifo_pop) parity_q <= ^fifo_rdata;
   end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

   localparam int unsigned CLK_DIV    = 4;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam logic [31:0] BASE       = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_rdata;
   logic        uart_tx;
   logic        tx_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] rx_q[$];
   logic       rx_par[$];
   int         rx_start[$];
   int         rx_ferr = 0;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_re    (bus_re),
      .bus_rdata (bus_rdata),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // Receiver model: finds the start edge, samples each bit mid-way.
   initial begin : monitor
      int t, k;
      bit act;
      logic [7:0] b;
      logic p;
      act = 0; t = 0; b = '0; p = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) act = 0;
         else if (!act) begin
            if (uart_tx === 1'b0) begin act = 1; t = 0; rx_start.push_back(cyc); end
         end else begin
            t++;
            if (t % CLK_DIV == CLK_DIV / 2) begin
               k = t / CLK_DIV;
               if (k == 0) begin
                  if (uart_tx !== 1'b0) rx_ferr++;
               end else if (k <= 8) b[k-1] = uart_tx;
               else if (k == NB - 1) begin
                  if (uart_tx !== 1'b1) rx_ferr++;
                  rx_q.push_back(b);
                  rx_par.push_back(p);
                  act = 0;
               end else p = uart_tx;
            end
         end
      end
   end

   // Expected line level at 'rel' cycles after the start bit begins.
   function automatic logic exp_line(input logic [7:0] b, input int rel);
      int k;
      if (rel < 0 || rel >= FRAME) return 1'b1;
      k = rel / CLK_DIV;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_addr = a; bus_wdata = d; bus_we = 1'b1;
      @(negedge clk);
      bus_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      bus_addr = a; bus_re = 1'b1;
      @(negedge clk);
      bus_re = 1'b0;
   endtask

   task automatic wait_rx(input int n, output bit timeout);
      int i;
      i = 0; timeout = 0;
      while (!(rx_q.size() >= n && tx_busy === 1'b0)) begin
         @(negedge clk);
         i++;
         if (i > 5000) begin timeout = 1; break; end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_rx();
      rx_q.delete(); rx_par.delete(); rx_start.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || bus_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got tx=%b busy=%b rdata=%h exp tx=1 busy=0 rdata=0", uart_tx, tx_busy, bus_rdata);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy);
      end
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h4) begin
         failures++; $display("FAIL reset_status got=%h exp=%h", bus_rdata, 32'h4);
      end
   endtask

   task automatic test_single();
      int n0, rel;
      logic e;
      bit to;
      clear_rx();
      wr(BASE, 32'hA5);
      n0 = cyc;
      for (int t = 0; t < FRAME + 6; t++) begin
         rel = cyc - (n0 + 2);
         e = exp_line(8'hA5, rel);
         checks++;
         if (uart_tx !== e) begin
            failures++; $display("FAIL single_wave rel=%0d got=%b exp=%b", rel, uart_tx, e);
         end
         @(negedge clk);
      end
      wait_rx(1, to);
      checks++;
      if (to || rx_q.size() != 1) begin
         failures++; $display("FAIL single_count got=%0d exp=1", rx_q.size());
      end else begin
         checks++;
         if (rx_q[0] !== 8'hA5) begin
            failures++; $display("FAIL single_byte got=%h exp=a5", rx_q[0]);
         end
         checks++;
         if (rx_start[0] != n0 + 2) begin
            failures++; $display("FAIL single_latency got=%0d exp=%0d", rx_start[0] - n0, 2);
         end
      end
      checks++;
      if (tx_busy !== 1'b0) begin
         failures++; $display("FAIL single_busy_end got=%b exp=0", tx_busy);
      end
   endtask

   task automatic test_regs();
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h4) begin failures++; $display("FAIL reg_status got=%h exp=4", bus_rdata); end
      rd(BASE);
      checks++;
      if (bus_rdata !== 32'h0) begin failures++; $display("FAIL reg_txdata_read got=%h exp=0", bus_rdata); end
      rd(BASE + 4);
      rd(BASE + 8);
      checks++;
      if (bus_rdata !== 32'h0) begin failures++; $display("FAIL reg_unmapped got=%h exp=0", bus_rdata); end
      rd(BASE + 4);
      rd(BASE + 1);
      checks++;
      if (bus_rdata !== 32'h0) begin failures++; $display("FAIL reg_misaligned got=%h exp=0", bus_rdata); end
      rd(BASE + 4);
      wr(BASE + 8, 32'h55);
      wr(BASE + 32'h1_0000, 32'h66);
      repeat (3) @(negedge clk);
      checks++;
      if (bus_rdata !== 32'h4) begin failures++; $display("FAIL reg_hold got=%h exp=4", bus_rdata); end
      checks++;
      if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
         failures++; $display("FAIL reg_no_push got busy=%b tx=%b exp busy=0 tx=1", tx_busy, uart_tx);
      end
   endtask

   task automatic test_burst5();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      bit to;
      clear_rx();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         wr(BASE, {24'h0, b});
      end
      repeat (50) @(negedge clk);
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h1) begin failures++; $display("FAIL burst5_midstatus got=%h exp=1", bus_rdata); end
      wait_rx(5, to);
      checks++;
      if (to || rx_q.size() != 5) begin
         failures++; $display("FAIL burst5_count got=%0d exp=5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
               failures++; $display("FAIL burst5_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
            end
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_start[i+1] - rx_start[i] != FRAME + 1) begin
               failures++; $display("FAIL burst5_gap%0d got=%0d exp=%0d", i, rx_start[i+1] - rx_start[i], FRAME + 1);
            end
         end
      end
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h4) begin failures++; $display("FAIL burst5_endstatus got=%h exp=4", bus_rdata); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      bit to;
      clear_rx();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         if (i < 5) exp_q.push_back(b);
         wr(BASE, {24'h0, b});
      end
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'hB) begin failures++; $display("FAIL ovf_status got=%h exp=b", bus_rdata); end
      // colliding load/store: clear takes effect, read shows pre-clear value
      bus_addr = BASE + 4; bus_wdata = 32'h8; bus_we = 1'b1; bus_re = 1'b1;
      @(negedge clk);
      bus_we = 1'b0; bus_re = 1'b0;
      checks++;
      if (bus_rdata !== 32'hB) begin failures++; $display("FAIL ovf_collide got=%h exp=b", bus_rdata); end
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h3) begin failures++; $display("FAIL ovf_cleared got=%h exp=3", bus_rdata); end
      wait_rx(5, to);
      repeat (FRAME + 4) @(negedge clk);
      checks++;
      if (to || rx_q.size() != 5) begin
         failures++; $display("FAIL ovf_count got=%0d exp=5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
               failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
            end
         end
      end
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h4) begin failures++; $display("FAIL ovf_endstatus got=%h exp=4", bus_rdata); end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int n;
      bit to;
      for (int r = 0; r < 6; r++) begin
         clear_rx();
         exp_q.delete();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wr(BASE, {24'h0, b});
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         wait_rx(n, to);
         checks++;
         if (to || rx_q.size() != n) begin
            failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, rx_q.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (rx_q[i] !== exp_q[i]) begin
                  failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", r, i, rx_q[i], exp_q[i]);
               end
            end
         end
         repeat ($urandom_range(1, 20)) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      bit to;
      clear_rx();
      wr(BASE, 32'hA5);
      n0 = cyc;
      wr(BASE, 32'h11);
      wr(BASE, 32'h22);
      while (cyc < n0 + 2 + 4 * 4 + 1) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0) begin failures++; $display("FAIL rstmid_bit3 got=%b exp=0", uart_tx); end
      reset = 1'b1;
      #1;
      checks++;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
         failures++; $display("FAIL rstmid_async got tx=%b busy=%b exp tx=1 busy=0", uart_tx, tx_busy);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      clear_rx();
      rd(BASE + 4);
      checks++;
      if (bus_rdata !== 32'h4) begin failures++; $display("FAIL rstmid_flushed got=%h exp=4", bus_rdata); end
      wr(BASE, 32'h3C);
      wait_rx(1, to);
      checks++;
      if (to || rx_q.size() != 1) begin
         failures++; $display("FAIL rstmid_count got=%0d exp=1", rx_q.size());
      end else begin
         checks++;
         if (rx_q[0] !== 8'h3C) begin failures++; $display("FAIL rstmid_byte got=%h exp=3c", rx_q[0]); end
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      int n0, rel;
      logic e;
      bit to;
      clear_rx();
      wr(BASE, 32'h07);
      n0 = cyc;
      wr(BASE, 32'h00);
      for (int t = 0; t < FRAME + 1; t++) begin
         rel = cyc - (n0 + 2);
         e = exp_line(8'h07, rel);
         checks++;
         if (uart_tx !== e) begin
            failures++; $display("FAIL parity_wave rel=%0d got=%b exp=%b", rel, uart_tx, e);
         end
         @(negedge clk);
      end
      wait_rx(2, to);
      checks++;
      if (to || rx_q.size() != 2) begin
         failures++; $display("FAIL parity_count got=%0d exp=2", rx_q.size());
      end else begin
         checks++;
         if (rx_par[0] !== 1'b1 || rx_par[1] !== 1'b0) begin
            failures++; $display("FAIL parity_bits got=%b%b exp=10", rx_par[0], rx_par[1]);
         end
         checks++;
         if (rx_start[1] - rx_start[0] != 45) begin
            failures++; $display("FAIL parity_frame_len got=%0d exp=45", rx_start[1] - rx_start[0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_regs();
      test_burst5();
      test_overflow();
      test_random();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      checks++;
      if (rx_ferr != 0) begin failures++; $display("FAIL framing_errors got=%0d exp=0", rx_ferr); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
